ysyx_24080006_mdu: RTL and testbench

- Iterative RV32M multiply/divide unit sitting beside the execute-stage ALU.
- Borrows the ALU's 33-bit adder each iteration: drives operands over the mdu2alu channel while holding mdu_enable, and consumes the sum on the alu2mdu channel.
- Accepts one operation at a time via a valid/ready handshake and returns a 32-bit result to writeback via valid/ready.

---
 rtl/ysyx_24080006_mdu_if.sv | 34 +++
 rtl/ysyx_24080006_mdu.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_24080006_mdu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_mdu_if.sv
// ----------------------------------------------------------------------------
// ysyx_24080006_mdu_if
// Bundles the request/response handshake of the multiply/divide unit together
// with the channel it uses to borrow the execute-stage ALU adder.
//   in_valid/in_ready   : request handshake (mdu_op, rs1, rs2 qualify it)
//   out_valid/out_ready : response handshake (result qualifies it)
//   mdu_enable          : MDU currently owns the ALU adder
//   mdu2alu             : {a[32:0], b[32:0]} adder operands
//   alu2mdu             : {res_34[33:0], res_32[31:0], not_zero} adder result
// master = pipeline/ALU side, slave = MDU side.
// ----------------------------------------------------------------------------
interface ysyx_24080006_mdu_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mdu_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        mdu_enable;
    logic [65:0] mdu2alu;
    logic [66:0] alu2mdu;

    modport master (
        output in_valid, mdu_op, rs1, rs2, out_ready, alu2mdu,
        input  in_ready, out_valid, result, mdu_enable, mdu2alu
    );

    modport slave (
        input  in_valid, mdu_op, rs1, rs2, out_ready, alu2mdu,
        output in_ready, out_valid, result, mdu_enable, mdu2alu
    );
endinterface

// File: rtl/ysyx_24080006_mdu.sv
// ----------------------------------------------------------------------------
// ysyx_24080006_mdu
// Iterative radix-2 RV32M multiply/divide unit. Operands are reduced to
// magnitudes on accept, 32 shift-add / restoring-subtract steps are run on the
// borrowed ALU adder, and the sign is restored in a single fix-up cycle.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-high reset
//   flush  : pipeline flush, aborts the current operation on the next edge
//   bus    : request/response handshake and ALU adder channel (slave side)
// Opcodes: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
// ----------------------------------------------------------------------------
module ysyx_24080006_mdu (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    ysyx_24080006_mdu_if.slave      bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_a_q, neg_a_d;       // rs1 was negative (and signed)
    logic        neg_b_q, neg_b_d;       // rs2 was negative (and signed)
    logic [31:0] hi_q, hi_d;             // product high half / remainder
    logic [31:0] lo_q, lo_d;             // multiplier-product low / quotient
    logic [31:0] opnd_q, opnd_d;         // |multiplicand| or |divisor|
    logic [31:0] result_q, result_d;
    logic        out_valid_q, out_valid_d;

    // Adder channel
    logic [32:0] alu_a, alu_b;
    logic        carry;
    logic [31:0] sum;
    logic        unused_alu_bits;

    assign carry           = bus.alu2mdu[66];
    assign sum             = bus.alu2mdu[32:1];
    assign unused_alu_bits = &{1'b0, bus.alu2mdu[65:33], bus.alu2mdu[0]};

    // Divide-step shifted views of {rem, quo}
    logic [31:0] rem_s, quo_s;
    assign rem_s = {hi_q[30:0], lo_q[31]};
    assign quo_s = {lo_q[30:0], 1'b0};

    // Operand decode for the accept cycle
    logic        is_div, sign1, sign2, div_zero, div_ovf;
    logic [31:0] mag1, mag2;
    assign is_div   = bus.mdu_op[2];
    assign sign1    = bus.rs1[31] & ((bus.mdu_op == 3'd1) | (bus.mdu_op == 3'd2) |
                                     (bus.mdu_op == 3'd4) | (bus.mdu_op == 3'd6));
    assign sign2    = bus.rs2[31] & ((bus.mdu_op == 3'd1) | (bus.mdu_op == 3'd4) |
                                     (bus.mdu_op == 3'd6));
    assign mag1     = sign1 ? (~bus.rs1 + 32'd1) : bus.rs1;
    assign mag2     = sign2 ? (~bus.rs2 + 32'd1) : bus.rs2;
    assign div_zero = is_div & (bus.rs2 == 32'd0);
    assign div_ovf  = ((bus.mdu_op == 3'd4) | (bus.mdu_op == 3'd6)) &
                      (bus.rs1 == 32'h8000_0000) & (bus.rs2 == 32'hFFFF_FFFF);

    // Sign fix-up views
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? (~lo_q + 32'd1) : lo_q;
    assign rem_fix  = neg_a_q ? (~hi_q + 32'd1) : hi_q;

    // Operands presented to the adder; kept separate from the state update so
    // the adder result feeds back without a combinational ordering loop.
    always_comb begin
        alu_a = 33'd0;
        alu_b = 33'd0;
        if (!op_q[2]) begin
            alu_a = {hi_q, 1'b0};
            alu_b = {(lo_q[0] ? opnd_q : 32'd0), 1'b0};
        end else begin
            alu_a = {rem_s, 1'b1};
            alu_b = {~opnd_q, 1'b1};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        result_d    = result_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.mdu_op;
                    neg_a_d = sign1;
                    neg_b_d = sign2;
                    cnt_d   = 5'd0;
                    hi_d    = 32'd0;
                    lo_d    = is_div ? mag1 : mag2;
                    opnd_d  = is_div ? mag2 : mag1;
                    if (div_zero) begin
                        result_d = bus.mdu_op[1] ? bus.rs1 : 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = bus.mdu_op[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!op_q[2]) begin
                    // {carry, sum, lo} >> 1
                    hi_d = {carry, sum[31:1]};
                    lo_d = {sum[0], lo_q[31:1]};
                end else if (hi_q[31] | carry) begin
                    // Shifted-out bit means the partial remainder exceeds 2^32,
                    // so the subtraction always fits.
                    hi_d = sum;
                    lo_d = {quo_s[31:1], 1'b1};
                end else begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                case (op_q)
                    3'd0:                result_d = prod_fix[31:0];
                    3'd1, 3'd2, 3'd3:    result_d = prod_fix[63:32];
                    3'd4, 3'd5:          result_d = quo_fix;
                    default:             result_d = rem_fix;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                // out_valid is registered, so it rises one edge after DONE
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = 5'd0;
            result_d    = 32'd0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            op_q        <= 3'd0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            opnd_q      <= 32'd0;
            result_q    <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.mdu_enable = (state_q == S_CALC);
    assign bus.mdu2alu    = (state_q == S_CALC) ? {alu_a, alu_b} : 66'd0;
endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24080006_mdu
// Directed test of the multiply/divide unit with a behavioural ALU adder.
// ----------------------------------------------------------------------------
module tb_ysyx_24080006_mdu;
    logic clock;
    logic reset;
    logic flush;
    int   total;
    int   bad;

    ysyx_24080006_mdu_if bus();

    ysyx_24080006_mdu dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // ALU adder: res_34 = {0,a} + {0,b}
    logic [33:0] alu_res;
    assign alu_res     = {1'b0, bus.mdu2alu[65:33]} + {1'b0, bus.mdu2alu[32:0]};
    assign bus.alu2mdu = {alu_res, alu_res[32:1], |alu_res[32:1]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency and adder ownership, optionally
    // stall the response for 'hold' cycles, then retire it.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat,
                          input int exp_en, input int hold);
        int j;
        int en;
        bit seen;
        bit stable;
        @(negedge clock);
        chk({tag, " in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.mdu_op   = op;
        bus.rs1      = a;
        bus.rs2      = b;
        @(posedge clock);
        j = 0; en = 0; seen = 1'b0;
        while (!seen && j < 100) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            if (bus.out_valid) seen = 1'b1;
            else begin
                if (bus.mdu_enable) en++;
                j++;
            end
        end
        chk({tag, " latency"}, j, exp_lat);
        chk({tag, " enable_cycles"}, en, exp_en);
        chk({tag, " result"}, bus.result, exp);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clock);
                if (!bus.out_valid || bus.in_ready || bus.result !== exp) stable = 1'b0;
            end
            chk({tag, " hold_stable"}, stable, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk({tag, " retired_out_valid"}, bus.out_valid, 0);
        chk({tag, " retired_in_ready"}, bus.in_ready, 1);
        $display("txn %s op=%0d rs1=%h rs2=%h result=%h lat=%0d en=%0d",
                 tag, op, a, b, bus.result, j, en);
    endtask

    // Start a long divide and abort it after 10 CALC cycles.
    task automatic abort_op(input string tag, input bit use_reset);
        int stale;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.mdu_op   = 3'd5;
        bus.rs1      = 32'd100;
        bus.rs2      = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clock);
        chk({tag, " in_calc"}, bus.mdu_enable, 1);
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        flush = 1'b0;
        chk({tag, " in_ready"}, bus.in_ready, 1);
        chk({tag, " out_valid"}, bus.out_valid, 0);
        chk({tag, " mdu_enable"}, bus.mdu_enable, 0);
        chk({tag, " result"}, bus.result, 0);
        chk({tag, " mdu2alu"}, bus.mdu2alu, 0);
        stale = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.out_valid || bus.mdu_enable) stale++;
        end
        chk({tag, " no_stale"}, stale, 0);
        $display("txn %s aborted", tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mdu_op    = 3'd0;
        bus.rs1       = 32'd0;
        bus.rs2       = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset result", bus.result, 0);
        chk("reset mdu_enable", bus.mdu_enable, 0);
        chk("reset mdu2alu", bus.mdu2alu, 0);
        reset = 1'b0;

        run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 32, 0);
        run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 32, 0);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 32, 0);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32, 0);
        run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 32, 0);
        run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 32, 0);
        run_op("divu",    3'd5, 32'd100,        32'd7,         32'd14,        34, 32, 0);
        run_op("remu",    3'd7, 32'd100,        32'd7,         32'd2,         34, 32, 0);
        run_op("divu_z",  3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1,  0,  0);
        run_op("remu_z",  3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 1,  0,  0);
        run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0,  0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0,  0);
        run_op("hold",    3'd0, 32'd12,         32'd11,        32'd132,       34, 32, 5);
        run_op("after",   3'd5, 32'd1000,       32'd10,        32'd100,       34, 32, 0);

        abort_op("flush", 1'b0);
        run_op("post_flush", 3'd0, 32'd3, 32'd5, 32'd15, 34, 32, 0);
        abort_op("reset", 1'b1);
        run_op("post_reset", 3'd6, 32'd17, 32'hFFFF_FFFB, 32'd2, 34, 32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
